// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: dual-slot circular instruction queue between fetch and IF/ID.
// Accepts up to two instructions per cycle and presents the two oldest entries.
module inst_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] INST_NOP = 32'h0340_0000
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst0,
    input  logic [31:0]                in_inst1,
    input  logic [31:0]                in_npc,
    input  logic                       in_branch,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output logic [31:0]                out_pc0,
    output logic [31:0]                out_pc1,
    output logic [31:0]                out_inst0,
    output logic [31:0]                out_inst1,
    output logic [31:0]                out_npc0,
    output logic [31:0]                out_npc1,
    output logic                       out_branch0,
    output logic                       out_branch1,
    input  logic [1:0]                 out_pop,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   npc_q  [DEPTH];
    logic          br_q   [DEPTH];
    logic [AW-1:0] head, tail, head1, tail1;
    logic [CW-1:0] push_n, req_n, pop_n;
    logic          two;

    assign in_ready = count <= CW'(DEPTH - 2);
    assign push_n   = !in_ready ? '0 : in_valid == 2'b11 ? CW'(2) : in_valid == 2'b01 ? CW'(1) : '0;
    assign req_n    = out_pop == 2'b11 ? CW'(2) : out_pop == 2'b01 ? CW'(1) : '0;
    assign pop_n    = req_n > count ? count : req_n;
    assign two      = push_n == CW'(2);
    assign head1    = head + AW'(1);
    assign tail1    = tail + AW'(1);

    always_ff @(posedge aclk) begin
        if (!aresetn || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + push_n - pop_n;
        end
    end

    // In a pair push the first slot falls through to the second, so it is never predicted taken.
    always_ff @(posedge aclk) begin
        if (aresetn && !flush && push_n != '0) begin
            pc_q[tail]   <= in_pc;
            inst_q[tail] <= in_inst0;
            npc_q[tail]  <= two ? in_pc + 32'd4 : in_npc;
            br_q[tail]   <= two ? 1'b0 : in_branch;
            if (two) begin
                pc_q[tail1]   <= in_pc + 32'd4;
                inst_q[tail1] <= in_inst1;
                npc_q[tail1]  <= in_npc;
                br_q[tail1]   <= in_branch;
            end
        end
    end

    assign out_valid   = {count >= CW'(2), count >= CW'(1)};
    assign out_pc0     = out_valid[0] ? pc_q[head]    : 32'd0;
    assign out_inst0   = out_valid[0] ? inst_q[head]  : INST_NOP;
    assign out_npc0    = out_valid[0] ? npc_q[head]   : 32'd0;
    assign out_branch0 = out_valid[0] ? br_q[head]    : 1'b0;
    assign out_pc1     = out_valid[1] ? pc_q[head1]   : 32'd0;
    assign out_inst1   = out_valid[1] ? inst_q[head1] : INST_NOP;
    assign out_npc1    = out_valid[1] ? npc_q[head1]  : 32'd0;
    assign out_branch1 = out_valid[1] ? br_q[head1]   : 1'b0;
endmodule
